// File: rtl/rv_commit_trace_buf.sv
// rv_commit_trace_buf
//   Show-ahead FIFO that captures the core's commit (retire) stream so a
//   trace consumer can drain it at its own pace. Every commit event gets a
//   32-bit sequence number. Filtered or dropped events therefore appear to
//   the consumer as gaps in the numbering. The core is never stalled. Events
//   that arrive while the buffer is full are dropped and counted.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   commit_valid  retire event present this cycle
//   commit_pc     PC of the retiring instruction
//   commit_rd     destination register
//   commit_data   write-back value
//   flush         synchronous clear of buffered entries
//   trace_ready   consumer accepts the head entry
//   trace_valid   head entry available
//   trace_pc      head PC
//   trace_rd      head rd
//   trace_data    head write-back value
//   trace_seq     head sequence number
//   count         current occupancy (0..DEPTH)
//   overflow      sticky: at least one event dropped on a full buffer
//   overflow_cnt  number of dropped events, saturating
module rv_commit_trace_buf #(
  parameter int unsigned DEPTH   = 16,
  parameter bit          DROP_X0 = 1'b1,
  parameter int unsigned OVF_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     commit_valid,
  input  logic [31:0]              commit_pc,
  input  logic [4:0]               commit_rd,
  input  logic [31:0]              commit_data,
  input  logic                     flush,
  input  logic                     trace_ready,
  output logic                     trace_valid,
  output logic [31:0]              trace_pc,
  output logic [4:0]               trace_rd,
  output logic [31:0]              trace_data,
  output logic [31:0]              trace_seq,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [OVF_W-1:0]         overflow_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] seq;
  } entry_t;

  entry_t          r_mem [DEPTH];
  entry_t          r_last;
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic [31:0]     r_seq;
  logic            r_ovf;
  logic [OVF_W-1:0] r_ovf_cnt;

  logic   w_push_req;
  logic   w_full;
  logic   w_empty;
  logic   w_pop;
  logic   w_push;
  logic   w_drop;
  entry_t w_head;
  entry_t w_out;

  always_comb begin
    w_push_req = commit_valid && !(DROP_X0 && (commit_rd == '0));
    w_full     = (r_count == CW'(DEPTH));
    w_empty    = (r_count == '0);
    w_pop      = !w_empty && trace_ready;
    // A full buffer still accepts the push when the head leaves in the same cycle.
    w_push     = w_push_req && !flush && (!w_full || w_pop);
    w_drop     = w_push_req && !flush && w_full && !w_pop;
    w_head     = r_mem[r_rptr];
    // Once empty, the outputs keep showing the last head that was presented.
    w_out      = w_empty ? r_last : w_head;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_seq     <= '0;
      r_ovf     <= 1'b0;
      r_ovf_cnt <= '0;
      r_last    <= '0;
    end else begin
      if (flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end

      // Sequence numbers are consumed by every commit, stored or not.
      if (commit_valid) r_seq <= r_seq + 1'b1;

      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_ovf_cnt != '1) r_ovf_cnt <= r_ovf_cnt + 1'b1;
      end

      // Track the currently presented head so it can be held after draining.
      if (!w_empty) r_last <= w_head;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= '{pc: commit_pc, rd: commit_rd, data: commit_data, seq: r_seq};
  end

  assign trace_valid  = !w_empty;
  assign trace_pc     = w_out.pc;
  assign trace_rd     = w_out.rd;
  assign trace_data   = w_out.data;
  assign trace_seq    = w_out.seq;
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign overflow_cnt = r_ovf_cnt;

endmodule

// File: tb/tb_rv_commit_trace_buf.sv
// Testbench for rv_commit_trace_buf: directed scenarios plus a random phase.
// A reference model predicts buffer contents in a queue; a monitor compares
// the presented head and status outputs every cycle and retires entries on pop.
module tb_rv_commit_trace_buf;

  localparam int unsigned DEPTH   = 16;
  localparam bit          DROP_X0 = 1'b1;
  localparam int unsigned OVF_W   = 4;
  localparam int unsigned OVF_MAX = (1 << OVF_W) - 1;

  logic        clk;
  logic        reset;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic [4:0]  commit_rd;
  logic [31:0] commit_data;
  logic        flush;
  logic        trace_ready;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [4:0]  trace_rd;
  logic [31:0] trace_data;
  logic [31:0] trace_seq;
  logic [4:0]  count;
  logic        overflow;
  logic [OVF_W-1:0] overflow_cnt;

  rv_commit_trace_buf #(
    .DEPTH  (DEPTH),
    .DROP_X0(DROP_X0),
    .OVF_W  (OVF_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .commit_valid(commit_valid),
    .commit_pc   (commit_pc),
    .commit_rd   (commit_rd),
    .commit_data (commit_data),
    .flush       (flush),
    .trace_ready (trace_ready),
    .trace_valid (trace_valid),
    .trace_pc    (trace_pc),
    .trace_rd    (trace_rd),
    .trace_data  (trace_data),
    .trace_seq   (trace_seq),
    .count       (count),
    .overflow    (overflow),
    .overflow_cnt(overflow_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] seq;
  } ent_t;

  // Reference model state
  ent_t        exp_q[$];
  ent_t        last_shown;
  int unsigned m_cnt;
  logic [31:0] m_seq;
  int unsigned m_ovf_cnt;
  logic        m_ovf;

  int unsigned n_vec;
  int unsigned n_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_cnt      = 0;
    m_seq      = '0;
    m_ovf_cnt  = 0;
    m_ovf      = 1'b0;
    last_shown = '{pc: '0, rd: '0, data: '0, seq: '0};
  endtask

  // One clock cycle of stimulus; the model is advanced just after the edge.
  task automatic step(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                      input logic [31:0] d, input logic fl, input logic rdy);
    logic pop;
    logic preq;
    @(negedge clk);
    commit_valid = v;
    commit_pc    = pc;
    commit_rd    = rd;
    commit_data  = d;
    flush        = fl;
    trace_ready  = rdy;
    @(posedge clk);
    #1;
    pop  = (m_cnt != 0) && rdy;
    preq = v && !(DROP_X0 && rd == 5'd0);
    if (fl) begin
      m_cnt = 0;
      exp_q.delete();
    end else if (preq) begin
      if (m_cnt < DEPTH || pop) begin
        exp_q.push_back('{pc: pc, rd: rd, data: d, seq: m_seq});
        if (!pop) m_cnt++;
      end else begin
        m_ovf = 1'b1;
        if (m_ovf_cnt < OVF_MAX) m_ovf_cnt++;
      end
    end else if (pop) begin
      m_cnt--;
    end
    if (v) m_seq = m_seq + 1;
  endtask

  task automatic commit(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] d,
                        input logic rdy);
    step(1'b1, pc, rd, d, 1'b0, rdy);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, '0, '0, '0, 1'b0, rdy);
  endtask

  // Asserts reset between clock edges and checks that it acts immediately.
  task automatic async_reset();
    #2;
    reset = 1'b0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_valid", trace_valid, 0);
    chk("rst_ovf_cnt", overflow_cnt, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_seq", trace_seq, 0);
    chk("rst_pc", trace_pc, 0);
    model_clear();
    commit_valid = 1'b0;
    flush        = 1'b0;
    trace_ready  = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Monitor: status every cycle, head content while valid, retire on pop.
  always @(negedge clk) begin
    #2;
    if (reset) begin
      chk("count", count, m_cnt);
      chk("valid", trace_valid, (m_cnt != 0));
      chk("overflow", overflow, m_ovf);
      chk("overflow_cnt", overflow_cnt, m_ovf_cnt);
      if (exp_q.size() != 0) begin
        chk("head_pc", trace_pc, exp_q[0].pc);
        chk("head_rd", trace_rd, exp_q[0].rd);
        chk("head_data", trace_data, exp_q[0].data);
        chk("head_seq", trace_seq, exp_q[0].seq);
        last_shown = exp_q[0];
        if (trace_ready) void'(exp_q.pop_front());
      end else begin
        chk("hold_pc", trace_pc, last_shown.pc);
        chk("hold_seq", trace_seq, last_shown.seq);
      end
    end
  end

  initial begin
    n_vec        = 0;
    n_err        = 0;
    reset        = 1'b0;
    commit_valid = 1'b0;
    commit_pc    = '0;
    commit_rd    = '0;
    commit_data  = '0;
    flush        = 1'b0;
    trace_ready  = 1'b0;
    model_clear();

    // Basic ordering and drain
    async_reset();
    commit(32'h0, 5'd1, 32'd5, 1'b0);
    commit(32'h4, 5'd2, 32'd7, 1'b0);
    commit(32'h8, 5'd3, 32'd9, 1'b0);
    chk("t1_count", count, 3);
    chk("t1_pc", trace_pc, 32'h0);
    chk("t1_data", trace_data, 32'd5);
    chk("t1_seq", trace_seq, 0);
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("t1_empty", trace_valid, 0);
    chk("t1_hold_seq", trace_seq, 2);

    // x0 filtering consumes sequence numbers
    async_reset();
    commit(32'h10, 5'd0, 32'h11, 1'b0);
    commit(32'h14, 5'd4, 32'h22, 1'b0);
    commit(32'h18, 5'd0, 32'h33, 1'b0);
    commit(32'h1c, 5'd5, 32'h44, 1'b0);
    chk("t2_count", count, 2);
    chk("t2_seq", trace_seq, 1);
    for (int i = 0; i < 2; i++) idle(1'b1);

    // Overflow on a full buffer
    async_reset();
    for (int i = 0; i < 21; i++) commit(32'(i * 4), 5'd7, $urandom(), 1'b0);
    chk("t3_count", count, 16);
    chk("t3_ovf", overflow, 1);
    chk("t3_ovf_cnt", overflow_cnt, 5);
    chk("t3_head_seq", trace_seq, 0);

    // Full with simultaneous pop: no drops
    for (int i = 0; i < 10; i++) commit(32'h100 + 32'(i * 4), 5'd9, $urandom(), 1'b1);
    chk("t4_count", count, 16);
    chk("t4_ovf_cnt", overflow_cnt, 5);
    chk("t4_head_seq", trace_seq, 10);

    // Flush with a same-cycle commit
    for (int i = 0; i < 16; i++) idle(1'b1);
    for (int i = 0; i < 4; i++) commit(32'h200 + 32'(i * 4), 5'd3, $urandom(), 1'b0);
    step(1'b1, 32'h300, 5'd6, 32'hdead, 1'b1, 1'b0);
    chk("t5_count", count, 0);
    chk("t5_valid", trace_valid, 0);
    commit(32'h304, 5'd6, 32'hbeef, 1'b0);
    chk("t5_seq", trace_seq, 36);
    chk("t5_ovf_cnt", overflow_cnt, 5);

    // Saturation of the drop counter
    for (int i = 0; i < 30; i++) commit($urandom() & ~32'h3, 5'd8, $urandom(), 1'b0);
    chk("t6_ovf_cnt", overflow_cnt, OVF_MAX);
    for (int i = 0; i < 16; i++) idle(1'b1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 9) < 7),
           $urandom() & ~32'h3,
           ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
           $urandom(),
           ($urandom_range(0, 29) == 0),
           $urandom_range(0, 1) == 1);
    end
    for (int i = 0; i < 20; i++) idle(1'b1);

    // Asynchronous reset in the middle of a drain
    for (int i = 0; i < 5; i++) commit(32'h400 + 32'(i * 4), 5'd2, $urandom(), 1'b0);
    idle(1'b1);
    idle(1'b1);
    async_reset();
    commit(32'h500, 5'd1, 32'h77, 1'b0);
    chk("t7_seq", trace_seq, 0);
    chk("t7_count", count, 1);
    for (int i = 0; i < 3; i++) idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
